// File: rtl/exe_stage_pkg.sv
// Shared definitions for the execute stage: bus widths, ALU opcode bit
// positions and the packed layouts of the decode->execute and
// execute->memory bundles.
package exe_stage_pkg;

  localparam int unsigned DS_TO_ES_BUS_WD = 151;
  localparam int unsigned ES_TO_MS_BUS_WD = 71;
  localparam int unsigned XLEN            = 32;
  localparam int unsigned REG_IDX_WD      = 5;
  localparam int unsigned ALU_OP_WD       = 12;
  localparam int unsigned SHAMT_WD        = 5;

  // One-hot alu_op bit positions
  localparam int unsigned OP_ADD  = 0;
  localparam int unsigned OP_SUB  = 1;
  localparam int unsigned OP_SLT  = 2;
  localparam int unsigned OP_SLTU = 3;
  localparam int unsigned OP_AND  = 4;
  localparam int unsigned OP_NOR  = 5;
  localparam int unsigned OP_OR   = 6;
  localparam int unsigned OP_XOR  = 7;
  localparam int unsigned OP_SLL  = 8;
  localparam int unsigned OP_SRL  = 9;
  localparam int unsigned OP_SRA  = 10;
  localparam int unsigned OP_LUI  = 11;

  // Decode -> execute bundle, MSB first
  typedef struct packed {
    logic [XLEN-1:0]       pc;
    logic [ALU_OP_WD-1:0]  alu_op;
    logic                  src2_is_4;
    logic                  src1_is_pc;
    logic                  src2_is_imm;
    logic                  gr_we;
    logic                  mem_we;
    logic [REG_IDX_WD-1:0] dest;
    logic [XLEN-1:0]       imm;
    logic [XLEN-1:0]       rj_value;
    logic [XLEN-1:0]       rkd_value;
    logic                  res_from_mem;
  } ds_to_es_bus_t;

  // Execute -> memory bundle, MSB first
  typedef struct packed {
    logic                  res_from_mem;
    logic                  gr_we;
    logic [REG_IDX_WD-1:0] dest;
    logic [XLEN-1:0]       alu_result;
    logic [XLEN-1:0]       pc;
  } es_to_ms_bus_t;

endpackage

// File: rtl/exe_stage_alu.sv
// Purely combinational ALU for the execute stage.
// Ports:
//   alu_op     in  12  one-hot operation select (bit positions in exe_stage_pkg)
//   src1       in  32  first operand
//   src2       in  32  second operand; src2[4:0] is the shift amount
//   alu_result out 32  result; zero when no op bit is set
module alu
  import exe_stage_pkg::*;
(
  input  logic [ALU_OP_WD-1:0] alu_op,
  input  logic [XLEN-1:0]      src1,
  input  logic [XLEN-1:0]      src2,
  output logic [XLEN-1:0]      alu_result
);

  logic [SHAMT_WD-1:0]    shamt;
  logic signed [XLEN-1:0] src1_s;
  logic [XLEN-1:0]        sra_res;
  logic                   lt_s;
  logic                   lt_u;

  assign shamt  = src2[SHAMT_WD-1:0];
  assign src1_s = src1;
  // Kept in its own signed context so the shift stays arithmetic
  assign sra_res = src1_s >>> shamt;
  assign lt_s    = $signed(src1) < $signed(src2);
  assign lt_u    = src1 < src2;

  // One-hot select: OR together the result of every enabled op
  always_comb begin
    alu_result = '0;
    if (alu_op[OP_ADD])  alu_result = alu_result | (src1 + src2);
    if (alu_op[OP_SUB])  alu_result = alu_result | (src1 - src2);
    if (alu_op[OP_SLT])  alu_result = alu_result | XLEN'(lt_s);
    if (alu_op[OP_SLTU]) alu_result = alu_result | XLEN'(lt_u);
    if (alu_op[OP_AND])  alu_result = alu_result | (src1 & src2);
    if (alu_op[OP_NOR])  alu_result = alu_result | ~(src1 | src2);
    if (alu_op[OP_OR])   alu_result = alu_result | (src1 | src2);
    if (alu_op[OP_XOR])  alu_result = alu_result | (src1 ^ src2);
    if (alu_op[OP_SLL])  alu_result = alu_result | (src1 << shamt);
    if (alu_op[OP_SRL])  alu_result = alu_result | (src1 >> shamt);
    if (alu_op[OP_SRA])  alu_result = alu_result | sra_res;
    if (alu_op[OP_LUI])  alu_result = alu_result | src2;
  end

endmodule

// File: rtl/exe_stage.sv
// Execute stage of the five-stage in-order pipeline. Latches the decode
// bundle, computes the ALU result, issues the data-SRAM request for
// ld.w/st.w and hands the result bundle to the memory stage.
// Optional feature macro: EXE_SRAM_HANDSHAKE_EN
//   defined   - the stage waits for data_sram_addr_ok before a memory op leaves
//   undefined - data_sram_addr_ok is ignored, data_sram_req is a plain enable
// Ports:
//   clk, resetn                     clock, asynchronous active-low reset
//   ds_to_es_valid/ds_to_es_bus     decode bundle in (151 bits)
//   es_allowin                      stage can accept a bundle
//   ms_allowin                      memory stage can accept
//   es_to_ms_valid/es_to_ms_bus     bundle out to memory stage (71 bits)
//   es_valid                        stage holds a valid instruction
//   es_to_ds_dest/load_op/forward   hazard and forwarding info to decode
//   data_sram_*                     data-SRAM request side
module exe_stage
  import exe_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       ds_to_es_valid,
  input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
  output logic                       es_allowin,
  input  logic                       ms_allowin,
  output logic                       es_to_ms_valid,
  output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       es_valid,
  output logic [REG_IDX_WD-1:0]      es_to_ds_dest,
  output logic                       es_to_ds_load_op,
  output logic [XLEN-1:0]            es_forward_data,
  output logic                       data_sram_req,
  output logic                       data_sram_wr,
  output logic [3:0]                 data_sram_wstrb,
  output logic [XLEN-1:0]            data_sram_addr,
  output logic [XLEN-1:0]            data_sram_wdata,
  input  logic                       data_sram_addr_ok
);

  ds_to_es_bus_t es_bus_q, es_bus_d;
  logic          es_valid_q, es_valid_d;
  logic          ds_accept;
  logic          mem_op;
  logic          req_done;
  logic          es_ready_go;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic [XLEN-1:0] alu_result;
  es_to_ms_bus_t   ms_bus;

  assign ds_accept = ds_to_es_valid & es_allowin;
  assign mem_op    = es_bus_q.mem_we | es_bus_q.res_from_mem;

  // Valid bit follows the upstream valid whenever the stage opens up;
  // the bundle itself only loads on a real transfer.
  always_comb begin
    es_valid_d = es_valid_q;
    es_bus_d   = es_bus_q;
    if (es_allowin) es_valid_d = ds_to_es_valid;
    if (ds_accept)  es_bus_d   = ds_to_es_bus_t'(ds_to_es_bus);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      es_valid_q <= 1'b0;
      es_bus_q   <= '0;
    end else begin
      es_valid_q <= es_valid_d;
      es_bus_q   <= es_bus_d;
    end
  end

`ifdef EXE_SRAM_HANDSHAKE_EN
  logic req_done_q, req_done_d;

  // Remember that the address phase completed so a stalled memory op
  // does not re-request; a newly latched bundle starts fresh.
  always_comb begin
    req_done_d = req_done_q;
    if (ds_accept)
      req_done_d = 1'b0;
    else if (data_sram_req & data_sram_addr_ok)
      req_done_d = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) req_done_q <= 1'b0;
    else         req_done_q <= req_done_d;
  end

  assign req_done    = req_done_q;
  assign es_ready_go = ~mem_op | req_done_q | data_sram_addr_ok;
`else
  logic unused_addr_ok;

  assign unused_addr_ok = data_sram_addr_ok;
  assign req_done       = 1'b0;
  assign es_ready_go    = 1'b1;
`endif

  assign es_allowin     = ~es_valid_q | (es_ready_go & ms_allowin);
  assign es_to_ms_valid = es_valid_q & es_ready_go;
  assign es_valid       = es_valid_q;

  // Operand selection; src2_is_4 relies on decode placing 4 in imm
  assign src1 = es_bus_q.src1_is_pc ? es_bus_q.pc : es_bus_q.rj_value;
  assign src2 = (es_bus_q.src2_is_imm | es_bus_q.src2_is_4) ? es_bus_q.imm
                                                             : es_bus_q.rkd_value;

  alu u_alu (
    .alu_op     (es_bus_q.alu_op),
    .src1       (src1),
    .src2       (src2),
    .alu_result (alu_result)
  );

  always_comb begin
    ms_bus              = '0;
    ms_bus.res_from_mem = es_bus_q.res_from_mem;
    ms_bus.gr_we        = es_bus_q.gr_we;
    ms_bus.dest         = es_bus_q.dest;
    ms_bus.alu_result   = alu_result;
    ms_bus.pc           = es_bus_q.pc;
  end

  assign es_to_ms_bus = ES_TO_MS_BUS_WD'(ms_bus);

  assign es_to_ds_dest    = (es_valid_q & es_bus_q.gr_we) ? es_bus_q.dest : '0;
  assign es_to_ds_load_op = es_valid_q & es_bus_q.res_from_mem;
  assign es_forward_data  = alu_result;

  // Word-only accesses: all byte lanes written on a store
  assign data_sram_req   = es_valid_q & mem_op & ~req_done;
  assign data_sram_wr    = es_bus_q.mem_we;
  assign data_sram_wstrb = {4{es_bus_q.mem_we}};
  assign data_sram_addr  = alu_result;
  assign data_sram_wdata = es_bus_q.rkd_value;

endmodule
